// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the digit-serial adder.
package serial_adder_pkg;

    localparam int unsigned MIN_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter that must hold 0..steps-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder: sum and majority carry, purely combinational.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Digit-serial WIDTH-bit adder, BPC bits per clock, LSB first, valid/ready on both sides.
// Optional subtract mode (sub port) enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned STEPS = (BPC == 0) ? 1 : WIDTH / BPC;
    localparam int unsigned CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (BPC == 0 || WIDTH < MIN_WIDTH || (WIDTH % BPC) != 0) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be >= %0d and a multiple of BPC", MIN_WIDTH);
    end

    state_e           state_q, state_d;
    logic             alive_q, alive_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [BPC:0]     chain_c;
    logic [BPC-1:0]   chain_s;

    assign chain_c[0] = carry_q;

    for (genvar i = 0; i < BPC; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .ci (chain_c[i]),
            .s  (chain_s[i]),
            .co (chain_c[i+1])
        );
    end

    assign in_ready  = alive_q && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d     = state_q;
        alive_d     = 1'b1;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        res_d       = res_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_ADDER_SUB_EN
                    // a - b as a + ~b + 1: invert B once here, seed the carry with 1
                    b_d     = sub ? ~b : b;
                    carry_d = sub | cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                end
            end
            RUN: begin
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                carry_d = chain_c[BPC];
                cnt_d   = cnt_q + CW'(1);
                res_d   = res_q >> BPC;
                res_d[WIDTH-1 -: BPC] = chain_s;
                if (cnt_q == LAST) begin
                    sum_d   = res_d;
                    cout_d  = chain_c[BPC];
                    ovf_d   = chain_c[BPC] ^ chain_c[BPC-1];
                    state_d = DONE;
                end
            end
            DONE: begin
                // out_valid rises one cycle after entering DONE; the result
                // is only released once it has actually been presented
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alive_q     <= 1'b0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            res_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alive_q     <= alive_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            res_q       <= res_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (BPC=1 and BPC=4 instances) and full_adder_cell.
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready, cin, cout, ovf, busy;
    logic [7:0] a, b, sum;

    logic       iv4, ir4, ov4, or4, cin4, cout4, ovf4, busy4;
    logic [7:0] a4, b4, sum4;

    logic       fa_a, fa_b, fa_ci, fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
    logic       sub, sub4;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    res_t sb[$];
    res_t sb4[$];

    serial_adder #(.WIDTH(8), .BPC(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    serial_adder #(.WIDTH(8), .BPC(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub4),
`endif
        .out_valid (ov4),
        .out_ready (or4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4),
        .busy      (busy4)
    );

    full_adder_cell u_fa (
        .a  (fa_a),
        .b  (fa_b),
        .ci (fa_ci),
        .s  (fa_s),
        .co (fa_co)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic c, input logic s);
        logic [7:0] yy;
        logic       cc;
        logic [8:0] t;
        res_t       r;
        yy = s ? ~y : y;
        cc = s ? 1'b1 : c;
        t  = {1'b0, x} + {1'b0, yy} + {8'b0, cc};
        r.sum  = t[7:0];
        r.cout = t[8];
        r.ovf  = (x[7] == yy[7]) && (t[7] != x[7]);
        return r;
    endfunction

    // One full transaction on the BPC=1 instance; 'hold' cycles of backpressure in DONE.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                         input logic ts, input int unsigned hold);
        res_t        e;
        int unsigned guard;
        int unsigned lat;
        logic [7:0]  held;
        sb.push_back(model(ta, tbv, tc, ts));
        a   = ta;
        b   = tbv;
        cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ts;
`endif
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        a   = 8'hC3;
        b   = 8'h3C;
        cin = ~tc;
        lat = 0;
        while (!out_valid && lat < 40) begin
            chk("ready_low_run", in_ready, 0);
            chk("busy_run", busy, 1);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 9);
        held = sum;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            a = 8'h33;
            b = 8'h44;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, held);
            chk("hold_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", cout, e.cout);
        chk("ovf", ovf, e.ovf);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drop_valid", out_valid, 0);
        chk("idle_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("retain_sum", sum, e.sum);
    endtask

    initial begin
        res_t        e;
        int unsigned lat;
        logic [2:0]  v;
        logic [1:0]  pc;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0; sub4 = 1'b0;
`endif

        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {fa_a, fa_b, fa_ci} = v;
            #1;
            pc = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
            chk("fa_s", fa_s, pc[0]);
            chk("fa_co", fa_co, pc[1]);
        end

        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        do_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 5);
        for (int i = 0; i < 4; i++)
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, i);

        // BPC=4 instance
        a4 = 8'hA5; b4 = 8'h5A; cin4 = 1'b1;
        sb4.push_back(model(8'hA5, 8'h5A, 1'b1, 1'b0));
        chk("r4_accept", ir4, 1);
        iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 20) begin
            chk("r4_ready_run", ir4, 0);
            @(negedge clk);
            lat++;
        end
        chk("r4_latency", lat, 3);
        chk("r4_ready_done", ir4, 0);
        e = sb4.pop_front();
        chk("r4_sum", sum4, e.sum);
        chk("r4_cout", cout4, e.cout);
        chk("r4_ovf", ovf4, e.ovf);
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        chk("r4_drop", ov4, 0);
        chk("r4_idle_ready", ir4, 1);

        // Abort mid-run; previous result must be cleared asynchronously
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        a = 8'h12; b = 8'h34; cin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_ready_after", in_ready, 1);
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
        do_op(8'h80, 8'h01, 1'b1, 1'b1, 2);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Digit-serial N-bit adder built from a chain of BPC full-adder cells and one carry register.
- Processes BPC bits per clock, LSB first. Ripple-adder area grows with WIDTH; this block trades that area for latency.
- Sits in the full-adder library as the first clocked, handshaked arithmetic block. It is the datapath core for later accumulator and MAC blocks.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- BPC, 1, bits processed per cycle; must divide WIDTH. Elaboration error otherwise.
- STEPS (localparam), WIDTH/BPC, cycles per operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and cin valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of MSB.
- ovf  out  1  signed overflow (carry into MSB XOR cout).
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous assert, active-low. All flops clear on rst_n=0 regardless of clk.
- Reset values: in_ready=0 while rst_n=0, 1 on the first cycle after release. out_valid=0, sum=0, cout=0, ovf=0, busy=0. Internal count=0, carry=0, state=IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register a, b; carry<=cin; count<=0; go to RUN.
- RUN, every cycle:
  - Add the low BPC bits of the A/B shift registers plus carry through the cell chain.
  - Shift the BPC sum bits into the result register from the MSB end.
  - Shift A/B right by BPC; carry<=chain carry-out; count++.
  - On the step with count==STEPS-1, also capture the carry into the MSB cell for ovf, then go to DONE.
- DONE:
  - out_valid=1; sum/cout/ovf held stable.
  - On out_ready: go to IDLE. out_valid drops the next cycle.
- Latency: in_valid accepted at edge k → out_valid high from edge k+STEPS+1 onward.
- Throughput: one op per STEPS+2 cycles minimum. No overlap; in_ready=0 in RUN and DONE.
- in_valid during RUN/DONE is ignored; operands are not sampled.
- out_ready while not in DONE is ignored. out_ready held low in DONE holds the result indefinitely.
- sum/cout/ovf retain the last result in IDLE until the next op reaches DONE. Consumers qualify with out_valid.
- Width rule: result is modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
- Reset mid-operation (rst_n low in RUN or DONE): operation aborted, no out_valid, all state to reset values.
- Handshake firings are sampled only on the rising clk edge.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with a/b on acceptance.
  - When sub=1, computes a + ~b + 1 (cin ignored, carry register seeded with 1).
  - cout=1 means no borrow; ovf is signed subtract overflow.
- Undefined: port absent, add-only; behaviour exactly as above.

Decomposition:
- Package serial_adder_pkg holds:
  - state enum type (IDLE, RUN, DONE);
  - STEPS-width count function;
  - constant MIN_WIDTH=2.
- One sub-module: full_adder_cell (a, b, ci → s, co), purely combinational.
  - s = a XOR b XOR ci.
  - co = majority of a, b, ci.
  - Instantiated BPC times in a generate loop.

Test Plan:
- full_adder_cell alone, all 8 input combos → s/co match truth table (e.g. 1,1,0 → s0 co1; 1,1,1 → s1 co1).
- WIDTH=8, BPC=1: a=0x0F, b=0x01, cin=0 → out_valid at edge k+9; sum=0x10, cout=0, ovf=0. Next: 0xFF+0x01 → sum=0x00, cout=1. Next: 0x7F+0x01 → sum=0x80, ovf=1.
- WIDTH=8, BPC=4: a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1 after 2 RUN cycles; in_ready=0 throughout RUN/DONE.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid and sum stable; in_valid pulses during that time are not accepted. out_ready=1 → IDLE next cycle.
- Reset mid-run: rst_n low at RUN count=3 → out_valid=0, busy=0, sum=0 immediately (async). in_ready=1 after release. A fresh op 0x01+0x01 → 0x02.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8: 0x05−0x07 → sum=0xFE, cout=0. 0x80−0x01 → sum=0x7F, ovf=1.
